dt_res_arbiter: RTL and testbench

//  Shares the single-port distance-transform result RAM (res_*) between two requesters:
//  req0 = DT pass engine (forward/backward), req1 = host readback/debug port.
//  One RAM access per cycle. Round-robin arbitration with a bounded hold. Read data is

---
 rtl/dt_pkg.sv | 21 ++
 rtl/dt_rr_pick.sv | 53 +++++
 rtl/dt_res_arbiter.sv | 119 +++++++++++
 tb/tb_dt_res_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared types for the distance-transform result RAM arbiter.
// Holds RAM widths, FSM state, requester id and the RAM command bundle.
package dt_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } arb_state_t;

  typedef logic rq_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } res_cmd_t;

endpackage

// File: rtl/dt_rr_pick.sv
// Two-way round-robin picker with a bounded hold on the current winner.
// Ports: clk, reset (sync, active-low), en, req[1:0] -> gnt[1:0], win_id.
module dt_rr_pick
  import dt_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output rq_id_t     win_id
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  logic          ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    unique case (req)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      default: win_id = ptr_q;
    endcase
    gnt    = '0;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    if (en && |req) begin
      gnt[win_id] = 1'b1;
      // A lone winner becomes preferred; hold only counts
      // while the loser is waiting.
      ptr_d  = win_id;
      hold_d = req[~win_id] ? hold_q + 1'b1 : '0;
      if (hold_d == HW'(MAX_HOLD)) begin
        ptr_d  = ~win_id;
        hold_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/dt_res_arbiter.sv
// Shares the single-port DT result RAM between the pass engine (0) and host (1).
// Ports: rq_* requester side, res_* RAM side, clr_done. Option: DT_RES_CLEAR_EN.
module dt_res_arbiter
  import dt_pkg::*;
#(
  parameter int MAX_HOLD = 4
`ifdef DT_RES_CLEAR_EN
  , parameter logic [DATA_W-1:0] CLR_VAL = '0
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             rq_req,
  input  logic [1:0]             rq_we,
  input  logic [1:0][ADDR_W-1:0] rq_addr,
  input  logic [1:0][DATA_W-1:0] rq_wdata,
  output logic [1:0]             rq_gnt,
  output logic [1:0]             rq_rvalid,
  output logic [DATA_W-1:0]      rq_rdata,
  output logic                   res_rd,
  output logic                   res_wr,
  output logic [ADDR_W-1:0]      res_addr,
  output logic [DATA_W-1:0]      res_do,
  input  logic [DATA_W-1:0]      res_di,
  output logic                   clr_done
);

`ifdef DT_RES_CLEAR_EN
  localparam arb_state_t RST_ST = CLEAR;
  logic [ADDR_W-1:0] clr_addr_q;
`else
  localparam arb_state_t RST_ST = ARB;
`endif

  arb_state_t        state_q;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] do_q;
  logic              v1_q, v2_q;
  rq_id_t            t1_q, t2_q;
  logic [1:0]        gnt;
  rq_id_t            win;
  logic              en;
  res_cmd_t          cmd;

  // Gate with reset so no grant is offered while reset is held.
  assign en = (state_q == ARB) && reset;

  dt_rr_pick #(
    .MAX_HOLD(MAX_HOLD)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .req   (rq_req),
    .gnt   (gnt),
    .win_id(win)
  );

  always_comb begin
    cmd = '{we: rq_we[win], addr: rq_addr[win], wdata: rq_wdata[win]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RST_ST;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      do_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      t1_q    <= 1'b0;
      t2_q    <= 1'b0;
`ifdef DT_RES_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= v1_q;
      t2_q <= t1_q;
      case (state_q)
`ifdef DT_RES_CLEAR_EN
        CLEAR: begin
          wr_q       <= 1'b1;
          addr_q     <= clr_addr_q;
          do_q       <= CLR_VAL;
          clr_addr_q <= clr_addr_q + 1'b1;
          if (&clr_addr_q) state_q <= ARB;
        end
`endif
        ARB: begin
          if (|gnt) begin
            rd_q   <= ~cmd.we;
            wr_q   <= cmd.we;
            addr_q <= cmd.addr;
            do_q   <= cmd.wdata;
            v1_q   <= ~cmd.we;
            t1_q   <= win;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign rq_gnt       = gnt;
  assign res_rd       = rd_q;
  assign res_wr       = wr_q;
  assign res_addr     = addr_q;
  assign res_do       = do_q;
  assign clr_done     = (state_q == ARB);
  assign rq_rvalid[0] = v2_q && (t2_q == 1'b0);
  assign rq_rvalid[1] = v2_q && (t2_q == 1'b1);
  assign rq_rdata     = v2_q ? res_di : '0;

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Self-checking bench for dt_res_arbiter with a RAM model and read scoreboard.
// Build with DT_RES_CLEAR_EN to exercise the clear engine.
module tb_dt_res_arbiter;
  import dt_pkg::*;

`ifdef DT_RES_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             rq_req;
  logic [1:0]             rq_we;
  logic [1:0][ADDR_W-1:0] rq_addr;
  logic [1:0][DATA_W-1:0] rq_wdata;
  logic [1:0]             rq_gnt;
  logic [1:0]             rq_rvalid;
  logic [DATA_W-1:0]      rq_rdata;
  logic                   res_rd;
  logic                   res_wr;
  logic [ADDR_W-1:0]      res_addr;
  logic [DATA_W-1:0]      res_do;
  logic [DATA_W-1:0]      res_di;
  logic                   clr_done;

  always #5 clk = ~clk;

  dt_res_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .rq_req   (rq_req),
    .rq_we    (rq_we),
    .rq_addr  (rq_addr),
    .rq_wdata (rq_wdata),
    .rq_gnt   (rq_gnt),
    .rq_rvalid(rq_rvalid),
    .rq_rdata (rq_rdata),
    .res_rd   (res_rd),
    .res_wr   (res_wr),
    .res_addr (res_addr),
    .res_do   (res_do),
    .res_di   (res_di),
    .clr_done (clr_done)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    if (CLR) return 8'hFF;
    return 8'(a ^ (a >> 7) ^ 32'h5A);
  endfunction

  // Synchronous single-port RAM model
  logic [7:0] ram_w [int];
  always @(posedge clk) begin
    if (res_wr === 1'b1) ram_w[int'(res_addr)] = res_do;
    if (res_rd === 1'b1) begin
      if (ram_w.exists(int'(res_addr))) res_di <= ram_w[int'(res_addr)];
      else res_di <= init_val(int'(res_addr));
    end
  end

  // Reference contents and read scoreboard
  logic [7:0] ref_w [int];
  function automatic logic [7:0] exp_val(input int a);
    if (ref_w.exists(a)) return ref_w[a];
    if (CLR) return 8'h00;
    return init_val(a);
  endfunction

  typedef struct {
    logic       id;
    logic [7:0] d;
  } sb_t;
  sb_t  sbq[$];
  logic [1:0] hs_seen = '0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rq_rvalid === 2'b11) chk("rv_onehot", rq_rvalid, 2'b01);
      for (int i = 0; i < 2; i++) begin
        if (rq_rvalid[i] === 1'b1) begin
          if (sbq.size() == 0) begin
            chk("rv_spurious", i, 32'hFFFF);
          end else begin
            sb_t e;
            e = sbq.pop_front();
            chk("rv_id", i, e.id);
            chk("rv_data", rq_rdata, e.d);
          end
        end
      end
      chk("gnt_onehot", $countones(rq_gnt) <= 1, 1);
      chk("gnt_no_req", rq_gnt & ~rq_req, 0);
      for (int i = 0; i < 2; i++) begin
        if (rq_req[i] && rq_gnt[i]) begin
          if (rq_we[i]) ref_w[int'(rq_addr[i])] = rq_wdata[i];
          else sbq.push_back('{id: 1'(i), d: exp_val(int'(rq_addr[i]))});
          hs_seen[i] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (clr_done !== 1'b1 && k < 20000) begin
      if (rq_gnt !== 2'b00) chk("clr_gnt", rq_gnt, 0);
      step();
      k++;
    end
    chk("clr_done", clr_done, 1);
  endtask

  task automatic do_reset(input logic [1:0] hold_req);
    reset  = 1'b0;
    rq_req = hold_req;
    rq_we  = '0;
    sbq.delete();
    if (CLR) ref_w.delete();
    step();
    step();
    reset = 1'b1;
    wait_ready();
    rq_req = '0;
  endtask

  initial begin
    int n0, n1;
    reset    = 1'b0;
    rq_req   = '0;
    rq_we    = '0;
    rq_addr  = '0;
    rq_wdata = '0;
    step();
    // held requests must not be granted during clear
    do_reset(2'b11);
    step();
    step();
    step();
    chk("sb_after_rst", sbq.size() <= 2, 1);

`ifdef DT_RES_CLEAR_EN
    // every word cleared
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      rq_req     = 2'b01;
      rq_we[0]   = 1'b0;
      rq_addr[0] = ADDR_W'(a);
      step();
    end
    rq_req = '0;
    step(); step(); step();
`endif

    // single read latency
    do_reset(2'b00);
    rq_req     = 2'b01;
    rq_we[0]   = 1'b0;
    rq_addr[0] = 14'h0081;
    @(negedge clk);
    chk("t1_gnt", rq_gnt, 2'b01);
    step();
    rq_req = '0;
    @(negedge clk);
    chk("t1_rd", res_rd, 1);
    chk("t1_wr", res_wr, 0);
    chk("t1_addr", res_addr, 14'h0081);
    step();
    @(negedge clk);
    chk("t1_rv", rq_rvalid, 2'b01);
    chk("t1_data", rq_rdata, exp_val(14'h0081));
    step();
    @(negedge clk);
    chk("t1_rv_pulse", rq_rvalid, 2'b00);
    step();

    // bounded hold pattern
    do_reset(2'b00);
    rq_req     = 2'b11;
    rq_we      = 2'b00;
    rq_addr[0] = 14'h0010;
    rq_addr[1] = 14'h0020;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t2_gnt", rq_gnt, ((k / 4) % 2) ? 2'b10 : 2'b01);
      step();
    end
    rq_req = '0;
    step(); step(); step();

    // write then read same address
    rq_req      = 2'b10;
    rq_we[1]    = 1'b1;
    rq_addr[1]  = 14'h1F7E;
    rq_wdata[1] = 8'h2A;
    @(negedge clk);
    chk("t3_wgnt", rq_gnt, 2'b10);
    step();
    rq_req     = 2'b01;
    rq_we[0]   = 1'b0;
    rq_addr[0] = 14'h1F7E;
    @(negedge clk);
    chk("t3_rgnt", rq_gnt, 2'b01);
    step();
    rq_req = '0;
    n0 = 0;
    n1 = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (rq_rvalid[0]) begin
        n0++;
        chk("t3_data", rq_rdata, 8'h2A);
      end
      if (rq_rvalid[1]) n1++;
      step();
    end
    chk("t3_rv0", n0, 1);
    chk("t3_rv1", n1, 0);

    // interleaved reads
    for (int k = 0; k < 4; k++) begin
      rq_req           = 2'b01 << (k % 2);
      rq_we[k % 2]     = 1'b0;
      rq_addr[k % 2]   = ADDR_W'(14'h0100 + k * 37);
      step();
    end
    rq_req = '0;
    step(); step(); step();
    chk("t4_drain", sbq.size(), 0);

    // random contention on a small address window
    hs_seen = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq_req[i] || hs_seen[i]) begin
          rq_req[i]   = ($urandom_range(0, 3) != 0);
          rq_we[i]    = 1'($urandom_range(0, 1));
          rq_addr[i]  = ADDR_W'($urandom_range(0, 31));
          rq_wdata[i] = 8'($urandom);
        end
        hs_seen[i] = 1'b0;
      end
      step();
    end
    rq_req = '0;
    step(); step(); step();
    chk("rnd_drain", sbq.size(), 0);

    // reset with a read in flight
    rq_req     = 2'b01;
    rq_we[0]   = 1'b0;
    rq_addr[0] = 14'h0123;
    @(negedge clk);
    chk("t6_gnt", rq_gnt, 2'b01);
    step();
    rq_req = 2'b11;
    reset  = 1'b0;
    sbq.delete();
    if (CLR) ref_w.delete();
    step();
    @(negedge clk);
    chk("t6_rd", res_rd, 0);
    chk("t6_wr", res_wr, 0);
    chk("t6_addr", res_addr, 0);
    chk("t6_do", res_do, 0);
    chk("t6_gnt_rst", rq_gnt, 0);
    chk("t6_rv", rq_rvalid, 0);
    chk("t6_rdata", rq_rdata, 0);
    chk("t6_clr_done", clr_done, !CLR);
    step();
    rq_req = '0;
    reset  = 1'b1;
    n0 = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (rq_rvalid != 2'b00) n0++;
      step();
    end
    chk("t6_no_rv", n0, 0);
    wait_ready();
    step(); step();
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
